// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor-series engine: mode codes, FSM states,
// reciprocal recurrence constants and the per-mode latency helper.
package taylor_pkg;

    localparam logic [1:0] MODE_EXP = 2'd0;
    localparam logic [1:0] MODE_SIN = 2'd1;
    localparam logic [1:0] MODE_COS = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    // Term index width; N_TERMS is limited to 12 so k never exceeds 12.
    localparam int K_W     = 4;
    localparam int R_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SQR   = 3'd1,
        ST_MUL_T = 3'd2,
        ST_MUL_R = 3'd3,
        ST_ACC   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic int fx_one(input int frac);
        return 32'sd1 << frac;
    endfunction

    // Recurrence constant for term k, unsigned Q0.frac rounded to nearest.
    // A zero denominator (k=0 or reserved mode) yields 0.
    function automatic int recip(input logic [1:0] mode, input int k, input int frac);
        int den;
        case (mode)
            MODE_EXP: den = k;
            MODE_SIN: den = (32'sd2 * k) * (32'sd2 * k + 32'sd1);
            MODE_COS: den = (32'sd2 * k - 32'sd1) * (32'sd2 * k);
            default:  den = 32'sd0;
        endcase
        if (den <= 32'sd0) begin
            return 32'sd0;
        end else begin
            return (fx_one(frac) + den / 32'sd2) / den;
        end
    endfunction

    // Cycles from the accepting clock edge to the edge where done rises.
    function automatic int latency(input logic [1:0] mode, input int w, input int n_terms);
        int l;
        l = (n_terms - 32'sd1) * (32'sd2 * w + 32'sd3) + 32'sd1;
        case (mode)
            MODE_EXP:           return l;
            MODE_SIN, MODE_COS: return l + w + 32'sd1;
            default:            return 32'sd1;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed W x W -> 2W.
// start loads the operands on its clock edge, then W add/shift edges follow;
// done pulses for one cycle once the product register is complete.
module booth_mul_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W + 1);

    // hi carries one extra bit so adding/subtracting the most negative
    // multiplicand never overflows the partial product.
    logic [W:0]    hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          qm1_q, qm1_d;
    logic [W-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [W:0]    m_ext_s;
    logic [W:0]    sum_s;

    // Booth recoding step and load/shift sequencing.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        m_ext_s = {m_q[W-1], m_q};
        case ({lo_q[0], qm1_q})
            2'b01:   sum_s = hi_q + m_ext_s;
            2'b10:   sum_s = hi_q - m_ext_s;
            default: sum_s = hi_q;
        endcase
        if (start) begin
            hi_d  = '0;
            lo_d  = b;
            qm1_d = 1'b0;
            m_d   = a;
            cnt_d = CW'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            {hi_d, lo_d, qm1_d} = {sum_s[W], sum_s, lo_q};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
                done_d = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier state registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            qm1_q  <= qm1_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign product = {hi_q[W-1:0], lo_q};

endmodule

// File: rtl/taylor_booth_engine.sv
// Taylor-series evaluator for exp/sin/cos in signed Q(W-FRAC).FRAC.
// Terms follow the recurrence t_k = (t_{k-1} * x or x^2) * R[mode][k], all
// products going through one shared sequential Booth multiplier.
module taylor_booth_engine
    import taylor_pkg::*;
#(
    parameter int W       = 16,
    parameter int FRAC    = 12,
    parameter int N_TERMS = 10,
    parameter int GUARD   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [W-1:0] x,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf
);

    localparam int ACC_W = W + GUARD;
    localparam int PW    = 2 * W;

    localparam logic [W-1:0]            ONE_W  = W'(fx_one(FRAC));
    localparam logic [K_W-1:0]          K_LAST = K_W'(N_TERMS - 1);
    localparam logic signed [PW-1:0]    P_MAX  = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0]    P_MIN  = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] A_MAX  = {{(GUARD+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] A_MIN  = {{(GUARD+1){1'b1}}, {(W-1){1'b0}}};

    // Rescale a full product by FRAC (floor) and clamp to W bits; MSB = clamped.
    function automatic logic [W:0] scale_sat(input logic [PW-1:0] prod);
        logic signed [PW-1:0] sh;
        sh = $signed(prod) >>> FRAC;
        if (sh > P_MAX) begin
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        end else if (sh < P_MIN) begin
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, sh[W-1:0]};
        end
    endfunction

    // Clamp the accumulator to W bits; MSB = clamped.
    function automatic logic [W:0] acc_sat(input logic [ACC_W-1:0] v);
        if ($signed(v) > A_MAX) begin
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        end else if ($signed(v) < A_MIN) begin
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, v[W-1:0]};
        end
    endfunction

    function automatic logic [ACC_W-1:0] sext_acc(input logic [W-1:0] v);
        return {{GUARD{v[W-1]}}, v};
    endfunction

    state_e            state_q, state_d;
    logic [W-1:0]      x_q, x_d;
    logic [W-1:0]      x2_q, x2_d;
    logic [W-1:0]      t_q, t_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [1:0]        mode_q, mode_d;
    logic              ovf_int_q, ovf_int_d;
    logic [W-1:0]      result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              accept_s;
    logic              mul_start_s;
    logic [W-1:0]      mul_a_s;
    logic [W-1:0]      mul_b_s;
    logic              mul_done_s;
    logic [PW-1:0]     mul_prod_s;
    logic [W:0]        prod_sat_s;
    logic [W:0]        acc_sat_s;
    logic [W-1:0]      r_cur_s;
    logic [W-1:0]      r_tab_s [4][R_DEPTH];

    // Reciprocal constants are elaboration-time values, one ROM row per mode.
    for (genvar gm = 0; gm < 4; gm++) begin : g_rmode
        for (genvar gk = 0; gk < R_DEPTH; gk++) begin : g_rk
            assign r_tab_s[gm][gk] = W'(recip(2'(gm), gk, FRAC));
        end
    end

    assign accept_s   = start & (state_q == ST_IDLE) & ~done_q;
    assign r_cur_s    = r_tab_s[mode_q][k_q];
    assign prod_sat_s = scale_sat(mul_prod_s);
    assign acc_sat_s  = acc_sat(acc_q);

    booth_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (mul_a_s),
        .b       (mul_b_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (mode)
                        MODE_EXP:           state_d = ST_MUL_T;
                        MODE_SIN, MODE_COS: state_d = ST_SQR;
                        default:            state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SQR: begin
                if (mul_done_s) state_d = ST_MUL_T;
                else            state_d = ST_SQR;
            end
            ST_MUL_T: begin
                if (mul_done_s) state_d = ST_MUL_R;
                else            state_d = ST_MUL_T;
            end
            ST_MUL_R: begin
                if (mul_done_s) state_d = ST_ACC;
                else            state_d = ST_MUL_R;
            end
            ST_ACC: begin
                if (k_q < K_LAST) state_d = ST_MUL_T;
                else              state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output values; each multiply is launched on the edge
    // that enters the state owning it, so its operands are chosen here.
    always_comb begin
        x_d         = x_q;
        x2_d        = x2_q;
        t_d         = t_q;
        acc_d       = acc_q;
        k_d         = k_q;
        mode_d      = mode_q;
        ovf_int_d   = ovf_int_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        mul_start_s = 1'b0;
        mul_a_s     = '0;
        mul_b_s     = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    x_d       = x;
                    mode_d    = mode;
                    k_d       = K_W'(1);
                    ovf_int_d = 1'b0;
                    case (mode)
                        MODE_EXP: begin
                            t_d         = ONE_W;
                            acc_d       = sext_acc(ONE_W);
                            mul_start_s = 1'b1;
                            mul_a_s     = ONE_W;
                            mul_b_s     = x;
                        end
                        MODE_SIN: begin
                            t_d         = x;
                            acc_d       = sext_acc(x);
                            mul_start_s = 1'b1;
                            mul_a_s     = x;
                            mul_b_s     = x;
                        end
                        MODE_COS: begin
                            t_d         = ONE_W;
                            acc_d       = sext_acc(ONE_W);
                            mul_start_s = 1'b1;
                            mul_a_s     = x;
                            mul_b_s     = x;
                        end
                        default: begin
                            t_d       = '0;
                            acc_d     = '0;
                            ovf_int_d = 1'b1;
                        end
                    endcase
                end else begin
                    mul_start_s = 1'b0;
                end
            end
            ST_SQR: begin
                if (mul_done_s) begin
                    x2_d        = prod_sat_s[W-1:0];
                    ovf_int_d   = ovf_int_q | prod_sat_s[W];
                    mul_start_s = 1'b1;
                    mul_a_s     = t_q;
                    mul_b_s     = prod_sat_s[W-1:0];
                end else begin
                    mul_start_s = 1'b0;
                end
            end
            ST_MUL_T: begin
                if (mul_done_s) begin
                    ovf_int_d   = ovf_int_q | prod_sat_s[W];
                    mul_start_s = 1'b1;
                    mul_a_s     = prod_sat_s[W-1:0];
                    mul_b_s     = r_cur_s;
                end else begin
                    mul_start_s = 1'b0;
                end
            end
            ST_MUL_R: begin
                if (mul_done_s) begin
                    t_d = prod_sat_s[W-1:0];
                end else begin
                    t_d = t_q;
                end
            end
            ST_ACC: begin
                // sin/cos alternate sign: odd k subtracts.
                if ((mode_q != MODE_EXP) && k_q[0]) begin
                    acc_d = acc_q - sext_acc(t_q);
                end else begin
                    acc_d = acc_q + sext_acc(t_q);
                end
                k_d = k_q + K_W'(1);
                if (k_q < K_LAST) begin
                    mul_start_s = 1'b1;
                    mul_a_s     = t_q;
                    mul_b_s     = (mode_q == MODE_EXP) ? x_q : x2_q;
                end else begin
                    mul_start_s = 1'b0;
                end
            end
            ST_DONE: begin
                result_d = acc_sat_s[W-1:0];
                ovf_d    = ovf_int_q | acc_sat_s[W];
                done_d   = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            x2_q      <= '0;
            t_q       <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            mode_q    <= MODE_EXP;
            ovf_int_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            x2_q      <= x2_d;
            t_q       <= t_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            mode_q    <= mode_d;
            ovf_int_q <= ovf_int_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_taylor_booth_engine.sv
// Scoreboard bench for taylor_booth_engine (W=16, FRAC=12, N_TERMS=10).
// The stimulus side pushes the expected result, flag and latency for every
// accepted request; a monitor pops and checks whenever done is seen.
// Expected values come from a bit-true integer evaluation of the truncating
// recurrence; hand results: exp(0)=4096, exp(1)=11130, exp(-1)=1505,
// sin(0.5)=1964, cos(1)=2213, sin(-0.5)=-1963, exp(3)=32767 with ovf.
module tb_taylor_booth_engine;
    import taylor_pkg::*;

    typedef struct {
        int res;
        bit ovf;
        int lat;
        int acc_cyc;
        int tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] x = 16'd0;
    logic        busy, done, ovf;
    logic [15:0] result;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag_ctr = 0;
    exp_t sb[$];

    taylor_booth_engine #(.W(16), .FRAC(12), .N_TERMS(10), .GUARD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic int fx_mul(input int a, input int b, output bit sat);
        longint pr;
        pr = (longint'(a) * longint'(b)) >>> 12;
        sat = 1'b0;
        if (pr > 64'sd32767) begin
            pr = 64'sd32767;
            sat = 1'b1;
        end else if (pr < -64'sd32768) begin
            pr = -64'sd32768;
            sat = 1'b1;
        end
        return int'(pr);
    endfunction

    function automatic void model(input logic [1:0] m, input int xv, output int res, output bit ov);
        int t, acc, x2, p, r, den, mulx;
        bit s, ovi;
        ovi = 1'b0;
        x2  = 0;
        if (m == 2'd3) begin
            res = 0;
            ov  = 1'b1;
            return;
        end
        if (m != 2'd0) begin
            x2 = fx_mul(xv, xv, s);
            ovi |= s;
        end
        t    = (m == 2'd1) ? xv : 4096;
        acc  = t;
        mulx = (m == 2'd0) ? xv : x2;
        for (int k = 1; k < 10; k++) begin
            if (m == 2'd0)      den = k;
            else if (m == 2'd1) den = (2 * k) * (2 * k + 1);
            else                den = (2 * k - 1) * (2 * k);
            r = (4096 + den / 2) / den;
            p = fx_mul(t, mulx, s);
            ovi |= s;
            t = fx_mul(p, r, s);
            if ((m != 2'd0) && (k % 2 == 1)) acc -= t;
            else                             acc += t;
        end
        ov = ovi;
        if (acc > 32767) begin
            acc = 32767;
            ov  = 1'b1;
        end else if (acc < -32768) begin
            acc = -32768;
            ov  = 1'b1;
        end
        res = acc;
    endfunction

    // Issue one request from idle and record what it must produce.
    task automatic issue(input logic [1:0] m, input logic signed [15:0] xv);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        x     = xv;
        @(posedge clk);
        #1;
        start     = 1'b0;
        e.acc_cyc = cyc;
        model(m, int'(xv), e.res, e.ovf);
        e.lat = latency(m, 16, 10);
        e.tag = tag_ctr;
        tag_ctr++;
        sb.push_back(e);
        @(negedge clk);
        check("busy_after_accept", {31'd0, busy}, 32'sd1);
    endtask

    // Wait until every outstanding request has been checked.
    task automatic drain();
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (i >= 1000) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare each done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with result %0d, required no done", $signed(result));
                end else begin
                    e = sb.pop_front();
                    $display("op %0d: result %0d ovf %0b latency %0d", e.tag, $signed(result), ovf, cyc - e.acc_cyc);
                    check("result", $signed(result), e.res);
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    check("latency", cyc - e.acc_cyc, e.lat);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'sd0);
        check("reset_done", {31'd0, done}, 32'sd0);
        check("reset_result", $signed(result), 32'sd0);
        check("reset_ovf", {31'd0, ovf}, 32'sd0);

        // Main function across modes and signs.
        issue(MODE_EXP, 16'sd0);     drain();
        issue(MODE_EXP, 16'sd4096);  drain();
        issue(MODE_EXP, -16'sd4096); drain();
        issue(MODE_SIN, 16'sd2048);  drain();
        issue(MODE_COS, 16'sd4096);  drain();
        issue(MODE_SIN, -16'sd2048); drain();

        // Saturation, then the flag clears on the next operation.
        issue(MODE_EXP, 16'sd12288); drain();
        issue(MODE_EXP, 16'sd0);     drain();

        // A second start while busy is dropped; result follows the first x.
        issue(MODE_EXP, 16'sd4096);
        repeat (4) @(negedge clk);
        start = 1'b1;
        mode  = MODE_EXP;
        x     = 16'sd8192;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reserved mode completes on the next cycle with ovf set.
        issue(MODE_RSV, 16'sd1234); drain();

        // A start during the done cycle is dropped.
        issue(MODE_EXP, 16'sd0);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, seen}, 32'sd1);
        start = 1'b1;
        mode  = MODE_RSV;
        x     = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_busy", {31'd0, busy}, 32'sd0);
        repeat (4) @(negedge clk);
        drain();

        // Reset in the middle of a run discards it; the next run is normal.
        issue(MODE_EXP, 16'sd4096);
        repeat (98) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", {31'd0, busy}, 32'sd0);
        check("midrst_done", {31'd0, done}, 32'sd0);
        check("midrst_result", $signed(result), 32'sd0);
        check("midrst_ovf", {31'd0, ovf}, 32'sd0);
        issue(MODE_EXP, 16'sd4096); drain();
        repeat (400) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
